// File: rtl/coyote_io_pkg.sv
// rtl/coyote_io_pkg.sv - shared defaults and helpers for pad input conditioning
package coyote_io_pkg;

  // Default synchronizer depth for asynchronous pad inputs (legal 2..4).
  localparam int DEF_SYNC_STAGES   = 2;

  // Default number of cycles a new level must persist before acceptance (legal 1..255).
  localparam int DEF_FILTER_CYCLES = 4;

  // Width of a counter that must hold values 0..cycles.
  function automatic int filt_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/pad_in_filter_bit.sv
// rtl/pad_in_filter_bit.sv - single-bit synchronizer, glitch filter and edge detector
module pad_in_filter_bit
  import coyote_io_pkg::*;
#(
  parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int   FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pad_i,
  input  logic filter_en_i,
  output logic data_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CNT_W     = filt_cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] LAST_FILT = CNT_W'(FILTER_CYCLES - 1);

  (* async_reg = "true" *) logic [SYNC_STAGES-1:0] sync_ff;

  logic             sync_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_last;
  logic             data_q;
  logic             data_d;
  logic             rise_q;
  logic             fall_q;
  logic             mismatch;
  logic             accept;

  assign sync_q   = sync_ff[SYNC_STAGES-1];

  // With the filter bypassed the last count is 0, so any mismatch is taken at once.
  assign cnt_last = filter_en_i ? LAST_FILT : '0;
  assign mismatch = (sync_q != data_q);

  // ">=" rather than "==" so a shrink of N mid-count still accepts on the next edge.
  assign accept   = mismatch && (cnt >= cnt_last);

  // Metastability chain: bit 0 samples the raw pad, the top bit is the stable copy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_ff <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], pad_i};
    end
  end

  // Persistence counter: counts consecutive mismatching cycles and commits the new level.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt    <= '0;
      data_q <= RESET_VAL;
    end else if (!mismatch) begin
      cnt    <= '0;
    end else if (accept) begin
      cnt    <= '0;
      data_q <= sync_q;
    end else begin
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Edge pulses come one cycle after data_q moves; data_d resets to the same level so reset never pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_d <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      data_d <= data_q;
      rise_q <= data_q & ~data_d;
      fall_q <= ~data_q & data_d;
    end
  end

  assign data_o = data_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/pad_in_conditioner.sv
// rtl/pad_in_conditioner.sv - per-bit synchronize, deglitch and edge-detect of a pad input bus
module pad_in_conditioner
  import coyote_io_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int               FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] pad_y_i,
  input  logic             filter_en_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             changed_o
);

  // Every bit is conditioned independently; nothing is shared between lanes.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pad_in_filter_bit #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_VAL     (RESET_VAL[i])
    ) u_bit (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .pad_i       (pad_y_i[i]),
      .filter_en_i (filter_en_i),
      .data_o      (data_o[i]),
      .rise_o      (rise_o[i]),
      .fall_o      (fall_o[i])
    );
  end

  // Only cross-bit logic: summary flag aligned with the registered edge pulses.
  assign changed_o = |(rise_o | fall_o);

endmodule
